instr_sequencer: RTL
====================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 The block SHALL have parameter HALT_OP, default 3'b111, meaning the opcode value that stops execution.
REQ-002 The block SHALL have parameter ICNT_W, default 8, meaning the width of the retired-instruction counter.
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 The block SHALL have port run  input  1  level; continuous execution while high.
REQ-006 The block SHALL have port step  input  1  single-cycle pulse; execute exactly one instruction.
REQ-007 The block SHALL have port clr  input  1  request to clear the program counter and instruction count.
REQ-008 The block SHALL have port op  input  3  opcode from the operand/op register: bit0 = RAM operand, bit2 = store result.
REQ-009 The block SHALL have port pc_en  output  1  PC increment and instruction-register load.
REQ-010 The block SHALL have port opnd_en  output  1  addr/x/y/op register load.
REQ-011 The block SHALL have port r_en  output  1  result register load.
REQ-012 The block SHALL have port mem_we  output  1  RAM write enable.
REQ-013 The block SHALL have port pc_clr  output  1  one-cycle PC clear pulse.
REQ-014 The block SHALL have the status ports busy, halted, state[2:0] and icount[ICNT_W-1:0], all outputs.

Function
REQ-015 The block SHALL implement the states IDLE=0, FETCH=1, DECODE=2, CHECK=3, MEMRD=4, EXEC=5, STORE=6 and HALTED=7, and SHALL drive state with the current encoding.
REQ-016 In IDLE, the block SHALL go to FETCH when run=1 (run mode) or when step=1 (step mode); if both are high, run mode SHALL take priority.
REQ-017 The transitions FETCH->DECODE->CHECK SHALL be unconditional.
REQ-018 pc_en SHALL be 1 only in FETCH.
REQ-019 opnd_en SHALL be 1 only in DECODE.
REQ-020 In CHECK, the block SHALL go to HALTED if op==HALT_OP, else to MEMRD if op[0]=1, else to EXEC.
REQ-021 MEMRD SHALL be a single wait state covering registered RAM read latency, and SHALL go to EXEC.
REQ-022 r_en SHALL be 1 only in EXEC.
REQ-023 EXEC SHALL go to STORE if op[2]=1; otherwise the instruction retires.
REQ-024 mem_we SHALL be 1 only in STORE; the instruction retires on leaving STORE.
REQ-025 Latency from FETCH entry to retirement SHALL be 4 cycles for a plain op, 5 with a RAM operand, 5 with a store, and 6 with both.
REQ-026 On retirement, icount SHALL increment by 1, wrapping from 2^ICNT_W-1 to 0.
REQ-027 On retirement, the next state SHALL be FETCH if in run mode with run=1, else IDLE.
REQ-028 run deasserted mid-instruction SHALL NOT abort the instruction; it completes and the block returns to IDLE.
REQ-029 step asserted outside IDLE SHALL be ignored; step is not queued.
REQ-030 In HALTED, the block SHALL stay halted regardless of run and step.
REQ-031 halted SHALL be 1 only in HALTED; the HALT instruction SHALL NOT increment icount.
REQ-032 clr=1 in IDLE or HALTED SHALL assert pc_clr for exactly one cycle, zero icount, and move to IDLE; this SHALL take priority over run and step in IDLE.
REQ-033 clr in any other state SHALL be ignored.
REQ-034 busy SHALL be 1 in states FETCH through STORE, and 0 in IDLE and HALTED.
REQ-035 All outputs SHALL be registered or decoded from state only, with no combinational path from run, step, clr or op to any output.

Reset
REQ-036 While reset=0 at a clock edge, the block SHALL set state to IDLE, icount to 0, clear the mode flag, and drive pc_en, opnd_en, r_en, mem_we, pc_clr, busy and halted to 0.
REQ-037 Reset SHALL override every input and abort any in-flight instruction, with no partial retirement and no mem_we after the reset edge.
REQ-038 After release, the first state change SHALL occur no earlier than the edge following the first edge with reset=1.

Verification
REQ-039 Step, op=3'b000: step pulse in IDLE -> states 1,2,3,5 then 0; pc_en, opnd_en and r_en each high for exactly one cycle; icount 0->1; mem_we never high.
REQ-040 Run, op=3'b101 held: run=1 -> states 1,2,3,4,5,6 repeating; one mem_we per 6 cycles; icount +1 per 6 cycles, wrapping 255->0 after 256 instructions.
REQ-041 Halt: run=1, op=3'b111 -> 1,2,3,7; halted=1, busy=0, icount unchanged; run and step toggling for 20 cycles -> stays in 7; then clr=1 -> pc_clr=1 for one cycle, state 0, icount=0.
REQ-042 Simultaneous inputs: run=1, step=1 and clr=1 in IDLE -> clr wins (pc_clr pulse, stay IDLE); next cycle run=1 and step=1 -> run mode, continuous fetch.
REQ-043 Mid-operation events: run dropped in MEMRD -> EXEC then IDLE, icount +1; reset=0 in STORE -> next cycle IDLE, all outputs 0, icount=0.

Source files
------------

// File: rtl/instr_sequencer.sv
// Control sequencer for a small accumulator-style datapath: walks each instruction
// through fetch/decode/check/operand-read/execute/store and counts retirements.
module instr_sequencer #(
  parameter logic [2:0] HALT_OP = 3'b111,
  parameter int         ICNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              step,
  input  logic              clr,
  input  logic [2:0]        op,
  output logic              pc_en,
  output logic              opnd_en,
  output logic              r_en,
  output logic              mem_we,
  output logic              pc_clr,
  output logic              busy,
  output logic              halted,
  output logic [2:0]        state,
  output logic [ICNT_W-1:0] icount
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_CHECK  = 3'd3,
    S_MEMRD  = 3'd4,
    S_EXEC   = 3'd5,
    S_STORE  = 3'd6,
    S_HALTED = 3'd7
  } state_t;

  localparam logic [ICNT_W-1:0] ICNT_ONE  = {{(ICNT_W-1){1'b0}}, 1'b1};
  localparam logic [ICNT_W-1:0] ICNT_ZERO = {ICNT_W{1'b0}};

  state_t            state_r;
  state_t            state_nx_s;
  logic              mode_r;
  logic              mode_nx_s;
  logic              armed_r;
  logic              retire_s;
  logic              clear_s;
  logic [ICNT_W-1:0] icount_r;
  logic              pc_en_r;
  logic              opnd_en_r;
  logic              r_en_r;
  logic              mem_we_r;
  logic              pc_clr_r;
  logic              busy_r;
  logic              halted_r;

  // Next-state decode; nothing moves until one full cycle after reset release.
  always_comb begin
    state_nx_s = state_r;
    mode_nx_s  = mode_r;
    retire_s   = 1'b0;
    clear_s    = 1'b0;
    if (armed_r) begin
      case (state_r)
        S_IDLE: begin
          if (clr) begin
            clear_s = 1'b1;
          end else if (run) begin
            state_nx_s = S_FETCH;
            mode_nx_s  = 1'b1;
          end else if (step) begin
            state_nx_s = S_FETCH;
            mode_nx_s  = 1'b0;
          end else begin
            state_nx_s = S_IDLE;
          end
        end
        S_FETCH:  state_nx_s = S_DECODE;
        S_DECODE: state_nx_s = S_CHECK;
        S_CHECK: begin
          if (op == HALT_OP) begin
            state_nx_s = S_HALTED;
          end else if (op[0]) begin
            state_nx_s = S_MEMRD;
          end else begin
            state_nx_s = S_EXEC;
          end
        end
        S_MEMRD: state_nx_s = S_EXEC;
        S_EXEC: begin
          if (op[2]) begin
            state_nx_s = S_STORE;
          end else begin
            retire_s = 1'b1;
          end
        end
        S_STORE: retire_s = 1'b1;
        S_HALTED: begin
          if (clr) begin
            clear_s = 1'b1;
          end else begin
            state_nx_s = S_HALTED;
          end
        end
        default: state_nx_s = S_IDLE;
      endcase

      // Continuous fetch only if the sequence was launched by run and run is still high.
      if (retire_s) begin
        state_nx_s = (mode_r && run) ? S_FETCH : S_IDLE;
      end else begin
        state_nx_s = state_nx_s;
      end

      if (clear_s) begin
        state_nx_s = S_IDLE;
        mode_nx_s  = 1'b0;
      end else begin
        mode_nx_s = mode_nx_s;
      end
    end else begin
      state_nx_s = state_r;
    end
  end

  // State, counter and registered outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r   <= S_IDLE;
      mode_r    <= 1'b0;
      armed_r   <= 1'b0;
      icount_r  <= ICNT_ZERO;
      pc_en_r   <= 1'b0;
      opnd_en_r <= 1'b0;
      r_en_r    <= 1'b0;
      mem_we_r  <= 1'b0;
      pc_clr_r  <= 1'b0;
      busy_r    <= 1'b0;
      halted_r  <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      mode_r    <= mode_nx_s;
      armed_r   <= 1'b1;
      if (clear_s) begin
        icount_r <= ICNT_ZERO;
      end else if (retire_s) begin
        icount_r <= icount_r + ICNT_ONE;
      end else begin
        icount_r <= icount_r;
      end
      pc_en_r   <= (state_nx_s == S_FETCH);
      opnd_en_r <= (state_nx_s == S_DECODE);
      r_en_r    <= (state_nx_s == S_EXEC);
      mem_we_r  <= (state_nx_s == S_STORE);
      pc_clr_r  <= clear_s;
      busy_r    <= (state_nx_s != S_IDLE) && (state_nx_s != S_HALTED);
      halted_r  <= (state_nx_s == S_HALTED);
    end
  end

  assign state   = state_r;
  assign icount  = icount_r;
  assign pc_en   = pc_en_r;
  assign opnd_en = opnd_en_r;
  assign r_en    = r_en_r;
  assign mem_we  = mem_we_r;
  assign pc_clr  = pc_clr_r;
  assign busy    = busy_r;
  assign halted  = halted_r;

endmodule
